// File: rtl/map_table_recovery_controller_if.sv
// ---------------------------------------------------------------------------
// map_table_recovery_controller_if
//   Bundles every non-clock/reset signal of the map table recovery controller.
//   Groups:
//     mispredict_*            branch unit -> controller, valid/ready
//     resolve_*               branch unit -> controller, valid/ready
//     rob_tail_index          ROB -> controller, next free ROB slot
//     restore_checkpoint_*    controller -> map table (success returns same cycle)
//     rob_walk_*              controller -> ROB read port, entry fields return
//     revert_*                controller -> map table, one mapping revert
//     dispatch_stall          controller -> front end
//     rob_tail_set_*          controller -> ROB tail truncation
//     recovery_done           controller -> pipeline, completion pulse
//   Modports:
//     master : the controller's view (drives map table / ROB requests)
//     slave  : the surrounding pipeline's view
// ---------------------------------------------------------------------------
interface map_table_recovery_controller_if #(
  parameter int unsigned ROB_INDEX_W = 6,
  parameter int unsigned ARCH_REG_W  = 5,
  parameter int unsigned PHYS_REG_W  = 6,
  parameter int unsigned COLUMN_W    = 2
);

  // Branch mispredict handshake
  logic                   mispredict_valid;
  logic                   mispredict_ready;
  logic [ROB_INDEX_W-1:0] mispredict_ROB_index;
  logic [COLUMN_W-1:0]    mispredict_column;

  // Correct-branch resolve handshake
  logic                   resolve_valid;
  logic                   resolve_ready;
  logic [ROB_INDEX_W-1:0] resolve_ROB_index;
  logic [COLUMN_W-1:0]    resolve_column;

  // ROB tail pointer
  logic [ROB_INDEX_W-1:0] rob_tail_index;

  // Map table checkpoint restore / invalidate
  logic                   restore_checkpoint_valid;
  logic                   restore_checkpoint_speculate_failed;
  logic [ROB_INDEX_W-1:0] restore_checkpoint_ROB_index;
  logic [COLUMN_W-1:0]    restore_checkpoint_safe_column;
  logic                   restore_checkpoint_success;

  // ROB walk read port
  logic [ROB_INDEX_W-1:0] rob_walk_index;
  logic                   rob_walk_writes_reg;
  logic [ARCH_REG_W-1:0]  rob_walk_dest_arch_reg_tag;
  logic [PHYS_REG_W-1:0]  rob_walk_safe_phys_reg_tag;
  logic [PHYS_REG_W-1:0]  rob_walk_speculated_phys_reg_tag;

  // Map table single-mapping revert
  logic                   revert_valid;
  logic [ARCH_REG_W-1:0]  revert_dest_arch_reg_tag;
  logic [PHYS_REG_W-1:0]  revert_safe_dest_phys_reg_tag;
  logic [PHYS_REG_W-1:0]  revert_speculated_dest_phys_reg_tag;

  // Pipeline control
  logic                   dispatch_stall;
  logic                   rob_tail_set_valid;
  logic [ROB_INDEX_W-1:0] rob_tail_set_index;
  logic                   recovery_done;

  modport master (
    input  mispredict_valid, mispredict_ROB_index, mispredict_column,
    output mispredict_ready,
    input  resolve_valid, resolve_ROB_index, resolve_column,
    output resolve_ready,
    input  rob_tail_index,
    output restore_checkpoint_valid, restore_checkpoint_speculate_failed,
    output restore_checkpoint_ROB_index, restore_checkpoint_safe_column,
    input  restore_checkpoint_success,
    output rob_walk_index,
    input  rob_walk_writes_reg, rob_walk_dest_arch_reg_tag,
    input  rob_walk_safe_phys_reg_tag, rob_walk_speculated_phys_reg_tag,
    output revert_valid, revert_dest_arch_reg_tag,
    output revert_safe_dest_phys_reg_tag, revert_speculated_dest_phys_reg_tag,
    output dispatch_stall, rob_tail_set_valid, rob_tail_set_index, recovery_done
  );

  modport slave (
    output mispredict_valid, mispredict_ROB_index, mispredict_column,
    input  mispredict_ready,
    output resolve_valid, resolve_ROB_index, resolve_column,
    input  resolve_ready,
    output rob_tail_index,
    input  restore_checkpoint_valid, restore_checkpoint_speculate_failed,
    input  restore_checkpoint_ROB_index, restore_checkpoint_safe_column,
    output restore_checkpoint_success,
    input  rob_walk_index,
    output rob_walk_writes_reg, rob_walk_dest_arch_reg_tag,
    output rob_walk_safe_phys_reg_tag, rob_walk_speculated_phys_reg_tag,
    input  revert_valid, revert_dest_arch_reg_tag,
    input  revert_safe_dest_phys_reg_tag, revert_speculated_dest_phys_reg_tag,
    input  dispatch_stall, rob_tail_set_valid, rob_tail_set_index, recovery_done
  );

endinterface

// File: rtl/map_table_recovery_controller.sv
// ---------------------------------------------------------------------------
// map_table_recovery_controller
//   Sequences branch-misprediction recovery of the physical register map
//   table. A mispredict first tries a checkpoint restore; if the map table
//   rejects it, the ROB is walked youngest-to-oldest down to (not including)
//   the branch, reverting one mapping per register-writing entry per cycle.
//   Correct-branch resolves are forwarded to the map table as checkpoint
//   invalidations while idle. Dispatch is stalled for the whole recovery.
//
// Ports:
//   CLK   clock
//   RST   synchronous active-high reset; every output is forced to 0 while high
//   bus   map_table_recovery_controller_if.master
//         (mispredict/resolve handshakes, ROB tail and walk port,
//          checkpoint restore/invalidate, revert, stall, tail truncation,
//          recovery_done)
// ---------------------------------------------------------------------------
module map_table_recovery_controller #(
  parameter int unsigned ROB_INDEX_W = 6,
  parameter int unsigned ARCH_REG_W  = 5,
  parameter int unsigned PHYS_REG_W  = 6,
  parameter int unsigned COLUMN_W    = 2
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  map_table_recovery_controller_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    WALK    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ROB_INDEX_W-1:0] IDX_ONE = ROB_INDEX_W'(1);

  state_t                 state,    state_nxt;
  logic [ROB_INDEX_W-1:0] br_idx,   br_idx_nxt;
  logic [COLUMN_W-1:0]    br_col,   br_col_nxt;
  logic [ROB_INDEX_W-1:0] walk_ptr, walk_ptr_nxt;

  // Oldest entry the walk may touch: the one just younger than the branch
  logic [ROB_INDEX_W-1:0] br_idx_plus1;

  // Combinational output values, gated to zero during reset
  logic                   mispredict_ready_c;
  logic                   resolve_ready_c;
  logic                   rc_valid_c;
  logic                   rc_spec_failed_c;
  logic [ROB_INDEX_W-1:0] rc_rob_index_c;
  logic [COLUMN_W-1:0]    rc_column_c;
  logic [ROB_INDEX_W-1:0] walk_index_c;
  logic                   revert_valid_c;
  logic [ARCH_REG_W-1:0]  revert_arch_c;
  logic [PHYS_REG_W-1:0]  revert_safe_c;
  logic [PHYS_REG_W-1:0]  revert_spec_c;
  logic                   dispatch_stall_c;
  logic                   tail_set_valid_c;
  logic [ROB_INDEX_W-1:0] tail_set_index_c;
  logic                   recovery_done_c;

  assign br_idx_plus1 = br_idx + IDX_ONE;

  // State and recovery context registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      br_idx   <= '0;
      br_col   <= '0;
      walk_ptr <= '0;
    end else begin
      state    <= state_nxt;
      br_idx   <= br_idx_nxt;
      br_col   <= br_col_nxt;
      walk_ptr <= walk_ptr_nxt;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt          = state;
    br_idx_nxt         = br_idx;
    br_col_nxt         = br_col;
    walk_ptr_nxt       = walk_ptr;

    mispredict_ready_c = 1'b0;
    resolve_ready_c    = 1'b0;
    rc_valid_c         = 1'b0;
    rc_spec_failed_c   = 1'b0;
    rc_rob_index_c     = '0;
    rc_column_c        = '0;
    walk_index_c       = '0;
    revert_valid_c     = 1'b0;
    revert_arch_c      = '0;
    revert_safe_c      = '0;
    revert_spec_c      = '0;
    dispatch_stall_c   = 1'b0;
    tail_set_valid_c   = 1'b0;
    tail_set_index_c   = '0;
    recovery_done_c    = 1'b0;

    // Reset overrides everything so no partial revert escapes in that cycle
    if (!RST) begin
      case (state)
        IDLE: begin
          mispredict_ready_c = 1'b1;
          if (bus.mispredict_valid) begin
            // Mispredict wins over resolve; the walk starts at the youngest entry
            dispatch_stall_c = 1'b1;
            br_idx_nxt       = bus.mispredict_ROB_index;
            br_col_nxt       = bus.mispredict_column;
            walk_ptr_nxt     = bus.rob_tail_index - IDX_ONE;
            state_nxt        = RESTORE;
          end else begin
            resolve_ready_c = 1'b1;
            if (bus.resolve_valid) begin
              // Invalidate the resolved branch's checkpoint; a reject is harmless
              rc_valid_c       = 1'b1;
              rc_spec_failed_c = 1'b0;
              rc_rob_index_c   = bus.resolve_ROB_index;
              rc_column_c      = bus.resolve_column;
            end
          end
        end

        RESTORE: begin
          dispatch_stall_c = 1'b1;
          rc_valid_c       = 1'b1;
          rc_spec_failed_c = 1'b1;
          rc_rob_index_c   = br_idx;
          rc_column_c      = br_col;
          // Nothing younger than the branch means there is nothing to walk
          if (bus.restore_checkpoint_success || (walk_ptr == br_idx)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = WALK;
          end
        end

        WALK: begin
          dispatch_stall_c = 1'b1;
          walk_index_c     = walk_ptr;
          revert_valid_c   = bus.rob_walk_writes_reg;
          revert_arch_c    = bus.rob_walk_dest_arch_reg_tag;
          revert_safe_c    = bus.rob_walk_safe_phys_reg_tag;
          revert_spec_c    = bus.rob_walk_speculated_phys_reg_tag;
          if (walk_ptr == br_idx_plus1) begin
            state_nxt = DONE;
          end else begin
            walk_ptr_nxt = walk_ptr - IDX_ONE;
          end
        end

        DONE: begin
          dispatch_stall_c = 1'b1;
          tail_set_valid_c = 1'b1;
          tail_set_index_c = br_idx_plus1;
          recovery_done_c  = 1'b1;
          state_nxt        = IDLE;
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Drive the interface
  assign bus.mispredict_ready                    = mispredict_ready_c;
  assign bus.resolve_ready                       = resolve_ready_c;
  assign bus.restore_checkpoint_valid            = rc_valid_c;
  assign bus.restore_checkpoint_speculate_failed = rc_spec_failed_c;
  assign bus.restore_checkpoint_ROB_index        = rc_rob_index_c;
  assign bus.restore_checkpoint_safe_column      = rc_column_c;
  assign bus.rob_walk_index                      = walk_index_c;
  assign bus.revert_valid                        = revert_valid_c;
  assign bus.revert_dest_arch_reg_tag            = revert_arch_c;
  assign bus.revert_safe_dest_phys_reg_tag       = revert_safe_c;
  assign bus.revert_speculated_dest_phys_reg_tag = revert_spec_c;
  assign bus.dispatch_stall                      = dispatch_stall_c;
  assign bus.rob_tail_set_valid                  = tail_set_valid_c;
  assign bus.rob_tail_set_index                  = tail_set_index_c;
  assign bus.recovery_done                       = recovery_done_c;

endmodule

// File: tb/tb_map_table_recovery_controller.sv
// ---------------------------------------------------------------------------
// tb_map_table_recovery_controller
//   Cycle-accurate scoreboard bench. Each scenario task pushes per-cycle
//   stimulus and the expected output snapshot for that cycle, then replays
//   the stimulus and compares the sampled outputs against the popped entry.
//   The ROB is modelled as arrays read combinationally at rob_walk_index.
// ---------------------------------------------------------------------------
module tb_map_table_recovery_controller;

  localparam int unsigned ROB_INDEX_W = 6;
  localparam int unsigned ARCH_REG_W  = 5;
  localparam int unsigned PHYS_REG_W  = 6;
  localparam int unsigned COLUMN_W    = 2;
  localparam int unsigned ROB_SIZE    = 64;

  typedef struct packed {
    logic       stall;
    logic       rcv;
    logic       rsf;
    logic [5:0] ridx;
    logic [1:0] rcol;
    logic [5:0] widx;
    logic       rv;
    logic [4:0] rarch;
    logic [5:0] rsafe;
    logic [5:0] rspec;
    logic       tsv;
    logic [5:0] tsi;
    logic       done;
    logic       mready;
    logic       rready;
  } snap_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] tail;
    logic       mv;
    logic [5:0] midx;
    logic [1:0] mcol;
    logic       rv;
    logic [5:0] ridx;
    logic [1:0] rcol;
    logic       succ;
  } stim_t;

  logic CLK;
  logic RST;

  map_table_recovery_controller_if #(
    .ROB_INDEX_W(ROB_INDEX_W), .ARCH_REG_W(ARCH_REG_W),
    .PHYS_REG_W(PHYS_REG_W), .COLUMN_W(COLUMN_W)
  ) bus ();

  map_table_recovery_controller #(
    .ROB_INDEX_W(ROB_INDEX_W), .ARCH_REG_W(ARCH_REG_W),
    .PHYS_REG_W(PHYS_REG_W), .COLUMN_W(COLUMN_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // ROB model
  logic       rob_wr   [ROB_SIZE];
  logic [4:0] rob_arch [ROB_SIZE];
  logic [5:0] rob_safe [ROB_SIZE];
  logic [5:0] rob_spec [ROB_SIZE];

  always_comb begin
    bus.rob_walk_writes_reg              = rob_wr[bus.rob_walk_index];
    bus.rob_walk_dest_arch_reg_tag       = rob_arch[bus.rob_walk_index];
    bus.rob_walk_safe_phys_reg_tag       = rob_safe[bus.rob_walk_index];
    bus.rob_walk_speculated_phys_reg_tag = rob_spec[bus.rob_walk_index];
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  stim_t stim_q[$];
  snap_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;

  task automatic apply(input stim_t s);
    RST                            = s.rst;
    bus.rob_tail_index             = s.tail;
    bus.mispredict_valid           = s.mv;
    bus.mispredict_ROB_index       = s.midx;
    bus.mispredict_column          = s.mcol;
    bus.resolve_valid              = s.rv;
    bus.resolve_ROB_index          = s.ridx;
    bus.resolve_column             = s.rcol;
    bus.restore_checkpoint_success = s.succ;
  endtask

  task automatic sample(output snap_t a);
    a.stall  = bus.dispatch_stall;
    a.rcv    = bus.restore_checkpoint_valid;
    a.rsf    = bus.restore_checkpoint_speculate_failed;
    a.ridx   = bus.restore_checkpoint_ROB_index;
    a.rcol   = bus.restore_checkpoint_safe_column;
    a.widx   = bus.rob_walk_index;
    a.rv     = bus.revert_valid;
    a.rarch  = bus.revert_dest_arch_reg_tag;
    a.rsafe  = bus.revert_safe_dest_phys_reg_tag;
    a.rspec  = bus.revert_speculated_dest_phys_reg_tag;
    a.tsv    = bus.rob_tail_set_valid;
    a.tsi    = bus.rob_tail_set_index;
    a.done   = bus.recovery_done;
    a.mready = bus.mispredict_ready;
    a.rready = bus.resolve_ready;
  endtask

  // Expected outputs in IDLE for the given requests
  function automatic snap_t idle_exp(input logic mv, input logic rv,
                                     input logic [5:0] ridx, input logic [1:0] rcol);
    snap_t e;
    e = '0;
    e.mready = 1'b1;
    if (mv) begin
      e.stall = 1'b1;
    end else begin
      e.rready = 1'b1;
      if (rv) begin
        e.rcv  = 1'b1;
        e.ridx = ridx;
        e.rcol = rcol;
      end
    end
    return e;
  endfunction

  function automatic snap_t walk_exp(input logic [5:0] p);
    snap_t e;
    e = '0;
    e.stall = 1'b1;
    e.widx  = p;
    e.rv    = rob_wr[p];
    e.rarch = rob_arch[p];
    e.rsafe = rob_safe[p];
    e.rspec = rob_spec[p];
    return e;
  endfunction

  // Whole mispredict recovery; requests stay asserted after acceptance to show they are ignored
  task automatic push_mispredict(input logic [5:0] tail, input logic [5:0] idx,
                                 input logic [1:0] col, input logic succ,
                                 input logic with_resolve, input logic trail);
    stim_t s;
    snap_t e;
    logic [5:0] p;
    s = '0;
    s.tail = tail; s.mv = 1'b1; s.midx = idx; s.mcol = col; s.succ = succ;
    if (with_resolve) begin
      s.rv = 1'b1; s.ridx = 6'd3; s.rcol = 2'd1;
    end
    stim_q.push_back(s);
    exp_q.push_back(idle_exp(1'b1, s.rv, s.ridx, s.rcol));
    s.rv = 1'b1; s.ridx = 6'd17; s.rcol = 2'd3;
    s.midx = idx ^ 6'h2a; s.mcol = ~col; s.tail = tail + 6'd7;
    // RESTORE
    stim_q.push_back(s);
    e = '0;
    e.stall = 1'b1; e.rcv = 1'b1; e.rsf = 1'b1; e.ridx = idx; e.rcol = col;
    exp_q.push_back(e);
    // WALK from youngest down to the entry just above the branch
    if (!succ) begin
      p = tail - 6'd1;
      while (p != idx) begin
        stim_q.push_back(s);
        exp_q.push_back(walk_exp(p));
        p = p - 6'd1;
      end
    end
    // DONE
    stim_q.push_back(s);
    e = '0;
    e.stall = 1'b1; e.tsv = 1'b1; e.tsi = idx + 6'd1; e.done = 1'b1;
    exp_q.push_back(e);
    if (trail) begin
      s = '0;
      stim_q.push_back(s);
      exp_q.push_back(idle_exp(1'b0, 1'b0, '0, '0));
    end
  endtask

  task automatic fill_rob_random();
    for (int i = 0; i < int'(ROB_SIZE); i++) begin
      rob_wr[i]   = 1'($urandom_range(0, 1));
      rob_arch[i] = 5'($urandom_range(0, 31));
      rob_safe[i] = 6'($urandom_range(0, 63));
      rob_spec[i] = 6'($urandom_range(0, 63));
    end
  endtask

  task automatic test_reset();
    stim_t s;
    snap_t act, e;
    s = '0; s.rst = 1'b1; s.mv = 1'b1; s.rv = 1'b1; s.tail = 6'd4;
    stim_q.push_back(s); exp_q.push_back('0);
    stim_q.push_back(s); exp_q.push_back('0);
    s = '0;
    stim_q.push_back(s); exp_q.push_back(idle_exp(1'b0, 1'b0, '0, '0));
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge CLK); sample(act); e = exp_q.pop_front(); cyc++;
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, act, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_restore_success();
    snap_t act, e;
    fill_rob_random();
    push_mispredict(6'd10, 6'd5, 2'd2, 1'b1, 1'b0, 1'b1);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge CLK); sample(act); e = exp_q.pop_front(); cyc++;
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL restore_success cyc=%0d got=%h exp=%h", cyc, act, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_restore_failure();
    snap_t act, e;
    fill_rob_random();
    rob_wr[8] = 1'b1; rob_wr[7] = 1'b0; rob_wr[6] = 1'b1;
    push_mispredict(6'd9, 6'd5, 2'd1, 1'b0, 1'b0, 1'b1);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge CLK); sample(act); e = exp_q.pop_front(); cyc++;
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL restore_failure cyc=%0d got=%h exp=%h", cyc, act, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_wrap();
    snap_t act, e;
    fill_rob_random();
    rob_wr[1] = 1'b1; rob_wr[0] = 1'b1; rob_wr[63] = 1'b1; rob_wr[62] = 1'b1;
    push_mispredict(6'd2, 6'd62, 2'd3, 1'b0, 1'b0, 1'b1);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge CLK); sample(act); e = exp_q.pop_front(); cyc++;
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, act, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_empty_walk();
    snap_t act, e;
    fill_rob_random();
    rob_wr[5] = 1'b1;
    push_mispredict(6'd6, 6'd5, 2'd0, 1'b0, 1'b0, 1'b1);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge CLK); sample(act); e = exp_q.pop_front(); cyc++;
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL empty_walk cyc=%0d got=%h exp=%h", cyc, act, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_priority();
    stim_t s;
    snap_t act, e;
    fill_rob_random();
    // Resolve alone; a rejected invalidate must change nothing
    s = '0; s.tail = 6'd20; s.rv = 1'b1; s.ridx = 6'd3; s.rcol = 2'd1; s.succ = 1'b0;
    stim_q.push_back(s); exp_q.push_back(idle_exp(1'b0, 1'b1, 6'd3, 2'd1));
    s = '0;
    stim_q.push_back(s); exp_q.push_back(idle_exp(1'b0, 1'b0, '0, '0));
    // Resolve and mispredict together: mispredict wins
    push_mispredict(6'd12, 6'd9, 2'd2, 1'b0, 1'b1, 1'b1);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge CLK); sample(act); e = exp_q.pop_front(); cyc++;
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL priority cyc=%0d got=%h exp=%h", cyc, act, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset_mid_walk();
    stim_t s;
    snap_t act, e;
    fill_rob_random();
    rob_wr[8] = 1'b1; rob_wr[7] = 1'b1;
    s = '0; s.tail = 6'd9; s.mv = 1'b1; s.midx = 6'd2; s.mcol = 2'd1;
    stim_q.push_back(s); exp_q.push_back(idle_exp(1'b1, 1'b0, '0, '0));
    s.mv = 1'b0;
    e = '0; e.stall = 1'b1; e.rcv = 1'b1; e.rsf = 1'b1; e.ridx = 6'd2; e.rcol = 2'd1;
    stim_q.push_back(s); exp_q.push_back(e);
    stim_q.push_back(s); exp_q.push_back(walk_exp(6'd8));
    s.rst = 1'b1;
    stim_q.push_back(s); exp_q.push_back('0);
    s = '0;
    stim_q.push_back(s); exp_q.push_back(idle_exp(1'b0, 1'b0, '0, '0));
    // Recovery after reset uses freshly latched context
    push_mispredict(6'd9, 6'd7, 2'd2, 1'b0, 1'b0, 1'b1);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge CLK); sample(act); e = exp_q.pop_front(); cyc++;
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL reset_mid_walk cyc=%0d got=%h exp=%h", cyc, act, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_back_to_back();
    snap_t act, e;
    fill_rob_random();
    push_mispredict(6'd30, 6'd26, 2'd1, 1'b0, 1'b0, 1'b0);
    push_mispredict(6'd40, 6'd33, 2'd3, 1'b1, 1'b0, 1'b0);
    push_mispredict(6'd0,  6'd60, 2'd2, 1'b0, 1'b0, 1'b1);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge CLK); sample(act); e = exp_q.pop_front(); cyc++;
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, act, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_random();
    snap_t act, e;
    logic [5:0] idx;
    logic [5:0] tail;
    for (int n = 0; n < 8; n++) begin
      fill_rob_random();
      idx  = 6'($urandom_range(0, 63));
      tail = idx + 6'd1 + 6'($urandom_range(0, 9));
      push_mispredict(tail, idx, 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      while (stim_q.size() != 0) begin
        apply(stim_q.pop_front());
        @(negedge CLK); sample(act); e = exp_q.pop_front(); cyc++;
        n_tests++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL random cyc=%0d got=%h exp=%h", cyc, act, e);
        end
        @(posedge CLK); #1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < int'(ROB_SIZE); i++) begin
      rob_wr[i] = 1'b0; rob_arch[i] = '0; rob_safe[i] = '0; rob_spec[i] = '0;
    end
    apply('0);
    RST = 1'b1;
    test_reset();
    test_restore_success();
    test_restore_failure();
    test_wrap();
    test_empty_walk();
    test_priority();
    test_reset_mid_walk();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
